red_pitaya_relock_ctrl: RTL and testbench

Rail-watchdog and relock sequencer for one lockbox channel. It monitors the limiter's two-bit railed status (bit 0 lower rail, bit 1 upper rail). When the channel stays railed for a programmable debounce time, it pulses a PID integrator reset, waits a hold-off, then resumes monitoring. After a programmable number of consecutive failed attempts it enters a latched fault that freezes the PID until software clears it. The block sits between the limiter status outputs and the PID reset/hold inputs, and is configured over the system bus.

---
 rtl/red_pitaya_relock_pkg.sv | 29 ++
 rtl/red_pitaya_relock_ctrl_if.sv | 20 ++
 rtl/red_pitaya_relock_cnt.sv | 39 +++
 rtl/red_pitaya_relock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_red_pitaya_relock_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_relock_pkg.sv
// Shared types and constants for the lockbox rail-watchdog / relock sequencer.
package red_pitaya_relock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_RESET    = 3'd3,
    ST_HOLDOFF  = 3'd4,
    ST_FAULT    = 3'd5
  } relock_state_e;

  localparam logic [19:0] ADDR_CTRL      = 20'h00000;
  localparam logic [19:0] ADDR_DEB_LEN   = 20'h00004;
  localparam logic [19:0] ADDR_HOLDOFF   = 20'h00008;
  localparam logic [19:0] ADDR_MAX_RETRY = 20'h0000C;
  localparam logic [19:0] ADDR_STABLE    = 20'h00010;
  localparam logic [19:0] ADDR_STATUS    = 20'h00014;
  localparam logic [19:0] ADDR_EVENTS    = 20'h00018;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_MASK_LO = 2;
  localparam int CTRL_MASK_HI = 3;

  localparam logic [7:0] MAX_RETRY_RST = 8'd3;
  localparam logic [1:0] RAIL_MASK_RST = 2'b11;

endpackage

// File: rtl/red_pitaya_relock_ctrl_if.sv
// System-bus port bundle of the relock controller.
interface red_pitaya_relock_ctrl_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_relock_cnt.sv
// Loadable saturating up-counter; done_o flags cnt >= max(term_i, 1).
module red_pitaya_relock_cnt #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] term_eff;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  // A programmed length of zero behaves like one.
  assign term_eff = (term_i == '0) ? W'(1) : term_i;
  assign done_o   = (cnt_q >= term_eff);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/red_pitaya_relock_ctrl.sv
// Rail watchdog for one lockbox channel: debounces limiter rail status, pulses
// the PID integrator reset, holds off, and latches a fault after repeated failures.
module red_pitaya_relock_ctrl
  import red_pitaya_relock_pkg::*;
#(
  parameter int RST_LEN = 16,
  parameter int CNT_W   = 24
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] railed_i,
  output logic       pid_rst_o,
  output logic       pid_hold_o,
  output logic       fault_o,
  red_pitaya_relock_ctrl_if.slave sys
);

  logic             enable_q;
  logic [1:0]       mask_q;
  logic [CNT_W-1:0] deb_len_q, holdoff_q, stable_q;
  logic [7:0]       max_retry_q;

  relock_state_e    state_q, state_d;
  logic [7:0]       retry_q, retry_d;
  logic [15:0]      events_q, events_d;
  logic             sticky_q, sticky_d;
  logic             rail_q;
  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             pid_rst_q, pid_hold_q, fault_q;

  logic             cnt_clr, cnt_load, cnt_inc, cnt_done;
  logic [CNT_W-1:0] cnt_term;
  logic             stab_clr, stab_done;

  logic [19:0]      addr;
  logic             fault_clr;
  logic             unused_bits;

  assign addr        = sys.sys_addr[19:0];
  assign fault_clr   = sys.sys_wen && (addr == ADDR_CTRL) && sys.sys_wdata[CTRL_CLR];
  assign unused_bits = ^{sys.sys_addr[31:20], sys.sys_wdata};

  // One counter times DEBOUNCE, RESET and HOLDOFF; the phases never overlap.
  red_pitaya_relock_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .load_val_i (CNT_W'(1)),
    .term_i     (cnt_term),
    .done_o     (cnt_done)
  );

  assign stab_clr = (state_q != ST_MONITOR) || rail_q || !enable_q;

  red_pitaya_relock_cnt #(.W(CNT_W)) u_stable_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (stab_clr),
    .load_i     (1'b0),
    .inc_i      (1'b1),
    .load_val_i ('0),
    .term_i     (stable_q),
    .done_o     (stab_done)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    events_d = events_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = deb_len_q;
    if (stab_done)
      retry_d = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (enable_q)
          state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (rail_q) begin
          state_d  = ST_DEBOUNCE;
          cnt_load = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!rail_q)
          state_d = ST_MONITOR;
        else if (cnt_done) begin
          if (retry_q >= max_retry_q)
            state_d = ST_FAULT;
          else begin
            state_d  = ST_RESET;
            cnt_load = 1'b1;
            retry_d  = retry_q + 8'd1;
          end
        end else
          cnt_inc = 1'b1;
      end
      ST_RESET: begin
        cnt_term = CNT_W'(RST_LEN);
        if (cnt_done) begin
          state_d  = ST_HOLDOFF;
          cnt_load = 1'b1;
        end else
          cnt_inc = 1'b1;
      end
      ST_HOLDOFF: begin
        cnt_term = holdoff_q;
        if (cnt_done)
          state_d = ST_MONITOR;
        else
          cnt_inc = 1'b1;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_MONITOR;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_q) begin
      state_d = ST_IDLE;
      retry_d = '0;
      cnt_clr = 1'b1;
    end
    if ((state_d == ST_RESET) && (state_q != ST_RESET) && (events_q != 16'hFFFF))
      events_d = events_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      events_q   <= '0;
      pid_rst_q  <= 1'b0;
      pid_hold_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      events_q   <= events_d;
      pid_rst_q  <= (state_d == ST_RESET);
      pid_hold_q <= (state_d == ST_FAULT);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign sticky_d = fault_clr ? 1'b0 : (sticky_q | rail_q);

  always_comb begin
    rdata_d = '0;
    if (sys.sys_ren) begin
      case (addr)
        ADDR_CTRL:      rdata_d = {28'd0, mask_q, 1'b0, enable_q};
        ADDR_DEB_LEN:   rdata_d = 32'(deb_len_q);
        ADDR_HOLDOFF:   rdata_d = 32'(holdoff_q);
        ADDR_MAX_RETRY: rdata_d = {24'd0, max_retry_q};
        ADDR_STABLE:    rdata_d = 32'(stable_q);
        ADDR_STATUS:    rdata_d = {20'd0, sticky_q, retry_q, state_q};
        ADDR_EVENTS:    rdata_d = {16'd0, events_q};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      enable_q    <= 1'b0;
      mask_q      <= RAIL_MASK_RST;
      deb_len_q   <= '0;
      holdoff_q   <= '0;
      stable_q    <= '0;
      max_retry_q <= MAX_RETRY_RST;
      sticky_q    <= 1'b0;
      rail_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sticky_q <= sticky_d;
      rail_q   <= |(railed_i & mask_q);
      ack_q    <= sys.sys_wen | sys.sys_ren;
      rdata_q  <= rdata_d;
      if (sys.sys_wen) begin
        case (addr)
          ADDR_CTRL: begin
            enable_q <= sys.sys_wdata[CTRL_EN];
            mask_q   <= sys.sys_wdata[CTRL_MASK_HI:CTRL_MASK_LO];
          end
          ADDR_DEB_LEN:   deb_len_q   <= sys.sys_wdata[CNT_W-1:0];
          ADDR_HOLDOFF:   holdoff_q   <= sys.sys_wdata[CNT_W-1:0];
          ADDR_MAX_RETRY: max_retry_q <= sys.sys_wdata[7:0];
          ADDR_STABLE:    stable_q    <= sys.sys_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign pid_rst_o     = pid_rst_q;
  assign pid_hold_o    = pid_hold_q;
  assign fault_o       = fault_q;
  assign sys.sys_ack   = ack_q;
  assign sys.sys_rdata = rdata_q;
  assign sys.sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_relock_ctrl.sv
// Directed bench for red_pitaya_relock_ctrl: register table plus relock/fault/stability sequences.
module tb_red_pitaya_relock_ctrl;

  localparam int RST_LEN = 16;
  localparam int CNT_W   = 24;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] railed = 2'b00;
  logic       pid_rst, pid_hold, fault;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  red_pitaya_relock_ctrl_if bus ();

  red_pitaya_relock_ctrl #(.RST_LEN(RST_LEN), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .railed_i   (railed),
    .pid_rst_o  (pid_rst),
    .pid_hold_o (pid_hold),
    .fault_o    (fault),
    .sys        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    tick();
    bus.sys_wen   = 1'b0;
    check("wr_ack", {31'd0, bus.sys_ack}, 32'd1);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    tick();
    bus.sys_ren  = 1'b0;
    check({name, "_ack"}, {31'd0, bus.sys_ack}, 32'd1);
    check(name, bus.sys_rdata, exp);
    $display("read  addr=0x%02h data=0x%0h (%s)", a, bus.sys_rdata, name);
  endtask

  function automatic logic sel_sig(input int sel);
    return (sel == 0) ? pid_rst : fault;
  endfunction

  // Advances until the chosen output reaches val; records the cycle stamp.
  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      tick();
      if (sel_sig(sel) === val) at = cyc;
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, want level %0b", name, bound, val);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    railed = 2'b00;
    tick(2);
    rstn = 1'b1;
    tick();
  endtask

  task automatic cfg(input int deb, input int ho, input int stab, input int maxr, input int ctrl);
    bus_write(32'h04, 32'(deb));
    bus_write(32'h08, 32'(ho));
    bus_write(32'h10, 32'(stab));
    bus_write(32'h0C, 32'(maxr));
    bus_write(32'h00, 32'(ctrl));
  endtask

  // Runs with the rail held until fault_o rises, counting pid_rst_o pulses.
  task automatic run_to_fault(input string name, input int bound, output int pulses);
    logic prev;
    int   t_f;
    prev   = 1'b0;
    pulses = 0;
    t_f    = -1;
    for (int i = 0; i < bound && t_f < 0; i++) begin
      tick();
      if (pid_rst && !prev) pulses++;
      prev = pid_rst;
      if (fault) t_f = cyc;
    end
    if (t_f < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: fault_o not seen within %0d cycles", name, bound);
    end
  endtask

  initial begin
    int   t0, t_rise, t_fall, t_r2, pulses;
    logic seen;

    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;

    vecs[0]  = '{1'b0, 32'h00, 32'h0, 32'h0C};
    vecs[1]  = '{1'b0, 32'h04, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0, 32'h3};
    vecs[4]  = '{1'b0, 32'h10, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h18, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h40, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h1C, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h04, 32'h12345678, 32'h345678};
    vecs[10] = '{1'b1, 32'h0C, 32'h1FF, 32'hFF};
    vecs[11] = '{1'b1, 32'h08, 32'hABCDEF01, 32'hCDEF01};
    vecs[12] = '{1'b1, 32'h00, 32'hE, 32'hC};
    vecs[13] = '{1'b1, 32'h00, 32'h4, 32'h4};
    vecs[14] = '{1'b0, 32'h4010000C, 32'h0, 32'hFF};
    vecs[15] = '{1'b1, 32'h10, 32'hFFFFFFFF, 32'hFFFFFF};

    // Reset state, sampled while rstn is still low.
    @(negedge clk);
    check("rst_pid_rst",  {31'd0, pid_rst},      32'd0);
    check("rst_pid_hold", {31'd0, pid_hold},     32'd0);
    check("rst_fault",    {31'd0, fault},        32'd0);
    check("rst_ack",      {31'd0, bus.sys_ack},  32'd0);
    check("rst_err",      {31'd0, bus.sys_err},  32'd0);
    check("rst_rdata",    bus.sys_rdata,         32'd0);
    tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      check("err", {31'd0, bus.sys_err}, 32'd0);
    end

    // Short rail burst is filtered by the debounce.
    do_reset();
    cfg(10, 0, 0, 3, 'hD);
    tick(2);
    railed = 2'b01;
    seen = 1'b0;
    repeat (8) begin tick(); seen |= pid_rst; end
    railed = 2'b00;
    repeat (20) begin tick(); seen |= pid_rst; end
    check("filt_no_rst", {31'd0, seen}, 32'd0);
    rd_check("filt_status", 32'h14, 32'h801);

    // Relock timing: rise latency, pulse width, hold-off, then disable mid-RESET.
    do_reset();
    cfg(10, 100, 0, 3, 'hD);
    tick(2);
    railed = 2'b10;
    tick();
    t0 = cyc;
    wait_sig("rise", 0, 1'b1, 50, t_rise);
    check("rise_latency", 32'(t_rise - t0), 32'd11);
    wait_sig("fall", 0, 1'b0, 50, t_fall);
    check("rst_width", 32'(t_fall - t_rise), 32'(RST_LEN));
    rd_check("events1", 32'h18, 32'd1);
    rd_check("holdoff_status", 32'h14, 32'h80C);
    wait_sig("rise2", 0, 1'b1, 200, t_r2);
    check("holdoff_to_rise", 32'(t_r2 - t_fall), 32'd111);
    tick(3);
    check("mid_reset", {31'd0, pid_rst}, 32'd1);
    bus_write(32'h00, 32'hC);
    tick();
    check("disable_rst_low", {31'd0, pid_rst}, 32'd0);
    rd_check("disable_status", 32'h14, 32'h800);
    rd_check("events2", 32'h18, 32'd2);

    // Masked rail is ignored.
    do_reset();
    cfg(2, 0, 0, 3, 'h5);
    tick(2);
    railed = 2'b10;
    seen = 1'b0;
    repeat (30) begin tick(); seen |= pid_rst; end
    check("mask_no_rst", {31'd0, seen}, 32'd0);
    rd_check("mask_status", 32'h14, 32'h001);

    // Fault after MAX_RETRY=2, latched until fault_clr.
    do_reset();
    cfg(3, 5, 0, 2, 'hD);
    tick(2);
    railed = 2'b11;
    run_to_fault("fault2", 400, pulses);
    check("fault_pulses", 32'(pulses), 32'd2);
    check("fault_hold", {31'd0, pid_hold}, 32'd1);
    check("fault_o", {31'd0, fault}, 32'd1);
    rd_check("fault_status", 32'h14, 32'h815);
    railed = 2'b00;
    tick(20);
    check("fault_latched", {31'd0, fault}, 32'd1);
    bus_write(32'h00, 32'h3);
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_hold", {31'd0, pid_hold}, 32'd0);
    rd_check("clr_status", 32'h14, 32'h001);

    // MAX_RETRY=0 goes straight to FAULT without a reset pulse.
    do_reset();
    cfg(1, 0, 0, 0, 'hD);
    tick(2);
    railed = 2'b01;
    run_to_fault("fault0", 50, pulses);
    check("fault0_pulses", 32'(pulses), 32'd0);

    // Stability window: 49 clean cycles keep retry_cnt, 50 clear it.
    do_reset();
    cfg(20, 5, 50, 3, 'hD);
    tick(2);
    railed = 2'b01;
    wait_sig("stab_rise", 0, 1'b1, 100, t_rise);
    wait_sig("stab_fall", 0, 1'b0, 50, t_fall);
    railed = 2'b00;
    tick(5 + 48);
    railed = 2'b01;
    tick(2);
    rd_check("stab49_status", 32'h14, 32'h80A);
    wait_sig("stab_rise2", 0, 1'b1, 100, t_rise);
    wait_sig("stab_fall2", 0, 1'b0, 50, t_fall);
    railed = 2'b00;
    tick(5 + 49);
    railed = 2'b01;
    tick(3);
    rd_check("stab50_status", 32'h14, 32'h802);

    // Asynchronous reset mid-RESET and mid-HOLDOFF with a read in flight.
    do_reset();
    cfg(1, 100, 0, 3, 'hD);
    tick(2);
    railed = 2'b11;
    wait_sig("ar_rise", 0, 1'b1, 50, t_rise);
    tick(2);
    rstn = 1'b0;
    #1;
    check("async_mid_reset", {31'd0, pid_rst}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    cfg(1, 100, 0, 3, 'hD);
    tick(2);
    wait_sig("ar_rise2", 0, 1'b1, 50, t_rise);
    wait_sig("ar_fall2", 0, 1'b0, 50, t_fall);
    tick(3);
    bus.sys_addr = 32'h14;
    bus.sys_ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_ren  = 1'b0;
    check("ho_ack", {31'd0, bus.sys_ack}, 32'd1);
    check("ho_rdata", bus.sys_rdata, 32'h80C);
    rstn = 1'b0;
    #1;
    check("async_ack", {31'd0, bus.sys_ack}, 32'd0);
    check("async_rdata", bus.sys_rdata, 32'd0);
    check("async_pid_rst", {31'd0, pid_rst}, 32'd0);
    check("async_hold", {31'd0, pid_hold}, 32'd0);
    check("async_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    railed = 2'b00;
    rstn = 1'b1;
    tick();
    rd_check("post_rst_status", 32'h14, 32'h0);
    rd_check("post_rst_events", 32'h18, 32'h0);
    rd_check("post_rst_maxr", 32'h0C, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
